// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encodings, load-bus bit positions and FSM state type for the MEM stage.
// Also holds the load-detection helper used when an instruction enters the stage.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 76;
    localparam int LOAD_WD      = 5;
    localparam int HILO_WD      = 66;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_TO_RF_WD = 38;
    localparam int STALL_WD     = 6;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Bit positions inside the one-hot {lb, lbu, lh, lhu, lw} load bus
    localparam int LD_LB  = 4;
    localparam int LD_LBU = 3;
    localparam int LD_LH  = 2;
    localparam int LD_LHU = 1;
    localparam int LD_LW  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] result;
    } ex_to_mem_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HAVE
    } mem_state_e;

    function automatic logic is_load(input ex_to_mem_t ex, input logic [LOAD_WD-1:0] ld);
        return ex.ram_en & (ex.ram_wen == 4'b0000) & (|ld);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data extractor: picks the addressed byte/half/word out of a
// little-endian 32-bit word and sign- or zero-extends it according to the load type.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [LOAD_WD-1:0] i_load_bus,
    input  logic [1:0]         i_addr,
    input  logic [31:0]        i_word,
    output logic [31:0]        o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        // Halfword loads ignore addr[0]; no alignment exception is raised here
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

        o_data = 32'h0000_0000;
        if (i_load_bus[LD_LB]) begin
            o_data = {{24{w_byte[7]}}, w_byte};
        end else if (i_load_bus[LD_LBU]) begin
            o_data = {24'h00_0000, w_byte};
        end else if (i_load_bus[LD_LH]) begin
            o_data = {{16{w_half[15]}}, w_half};
        end else if (i_load_bus[LD_LHU]) begin
            o_data = {16'h0000, w_half};
        end else if (i_load_bus[LD_LW]) begin
            o_data = i_word;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bundle, waits for a variable-latency SRAM load
// response, extends load data and drives the WB and forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [LOAD_WD-1:0]      ex_load_bus,
    input  logic [HILO_WD-1:0]      ex_hi_lo_bus,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    data_sram_rvalid,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
    output logic [HILO_WD-1:0]      mem_hi_lo_bus,
    output logic                    stallreq_for_mem
);

    ex_to_mem_t         w_ex;
    logic [31:0]        r_pc;
    logic               r_sel_rf_res;
    logic               r_rf_we;
    logic [4:0]         r_waddr;
    logic [31:0]        r_result;
    logic [LOAD_WD-1:0] r_load_bus;
    logic [HILO_WD-1:0] r_hi_lo_bus;
    logic [31:0]        r_hold;
    mem_state_e         r_state;

    logic [31:0]        w_word;
    logic [31:0]        w_load_data;
    logic [31:0]        w_wdata;
    logic               w_unused;

    assign w_ex     = ex_to_mem_t'(ex_to_mem_bus);
    assign w_unused = &{1'b0, stall[5], stall[2:0]};

    // Bubble takes priority over capture; a response arriving while MEM is held is
    // parked in r_hold so the SRAM data bus is free to change afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= '0;
            r_sel_rf_res <= 1'b0;
            r_rf_we      <= 1'b0;
            r_waddr      <= '0;
            r_result     <= '0;
            r_load_bus   <= '0;
            r_hi_lo_bus  <= '0;
            r_hold       <= '0;
            r_state      <= S_IDLE;
        end else if (stall[3] == Stop && stall[4] == NoStop) begin
            r_pc         <= '0;
            r_sel_rf_res <= 1'b0;
            r_rf_we      <= 1'b0;
            r_waddr      <= '0;
            r_result     <= '0;
            r_load_bus   <= '0;
            r_hi_lo_bus  <= '0;
            r_hold       <= '0;
            r_state      <= S_IDLE;
        end else if (stall[3] == NoStop) begin
            r_pc         <= w_ex.pc;
            r_sel_rf_res <= w_ex.sel_rf_res;
            r_rf_we      <= w_ex.rf_we;
            r_waddr      <= w_ex.waddr;
            r_result     <= w_ex.result;
            r_load_bus   <= ex_load_bus;
            r_hi_lo_bus  <= ex_hi_lo_bus;
            r_state      <= is_load(w_ex, ex_load_bus) ? S_WAIT : S_IDLE;
        end else if (r_state == S_WAIT && data_sram_rvalid) begin
            r_hold  <= data_sram_rdata;
            r_state <= S_HAVE;
        end
    end

    assign w_word = (r_state == S_HAVE) ? r_hold : data_sram_rdata;

    load_align u_load_align (
        .i_load_bus (r_load_bus),
        .i_addr     (r_result[1:0]),
        .i_word     (w_word),
        .o_data     (w_load_data)
    );

    assign w_wdata          = r_sel_rf_res ? w_load_data : r_result;
    assign mem_to_wb_bus    = {r_pc, r_rf_we, r_waddr, w_wdata};
    assign mem_to_rf_bus    = {r_rf_we, r_waddr, w_wdata};
    assign mem_hi_lo_bus    = r_hi_lo_bus;
    assign stallreq_for_mem = (r_state == S_WAIT) & ~data_sram_rvalid;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by randomized traffic,
// all compared against a transaction-level model of the instruction sitting in MEM.
module tb_mem_stage;

    localparam logic [5:0] RUN    = 6'b000000;
    localparam logic [5:0] HOLD   = 6'b011111;
    localparam logic [5:0] BUBBLE = 6'b001111;

    localparam logic [4:0] LB  = 5'b10000;
    localparam logic [4:0] LBU = 5'b01000;
    localparam logic [4:0] LH  = 5'b00100;
    localparam logic [4:0] LHU = 5'b00010;
    localparam logic [4:0] LW  = 5'b00001;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [75:0] exBus;
    logic [4:0]  loadBus;
    logic [65:0] hiLoBus;
    logic [31:0] rdata;
    logic        rvalid;
    logic [69:0] wbBus;
    logic [37:0] rfBus;
    logic [65:0] hiLoOut;
    logic        stallReq;

    // Model of whatever instruction currently occupies MEM
    logic [31:0] mPc;
    logic        mRfWe;
    logic [4:0]  mWaddr;
    logic [31:0] mResult;
    logic        mSel;
    logic [4:0]  mLoad;
    logic [65:0] mHiLo;
    logic        mIsLoad;
    logic        mHave;
    logic [31:0] mData;

    int checkCount;
    int passCount;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .ex_to_mem_bus    (exBus),
        .ex_load_bus      (loadBus),
        .ex_hi_lo_bus     (hiLoBus),
        .data_sram_rdata  (rdata),
        .data_sram_rvalid (rvalid),
        .mem_to_wb_bus    (wbBus),
        .mem_to_rf_bus    (rfBus),
        .mem_hi_lo_bus    (hiLoOut),
        .stallreq_for_mem (stallReq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [75:0] mkEx(input logic [31:0] pc, input logic ramEn, input logic [3:0] wen,
                                         input logic sel, input logic rfWe, input logic [4:0] waddr,
                                         input logic [31:0] result);
        return {pc, ramEn, wen, sel, rfWe, waddr, result};
    endfunction

    // Arithmetic extraction: shift the word down by the byte offset, mask, then extend
    function automatic logic [31:0] extendLoad(input logic [4:0] ld, input logic [31:0] addr, input logic [31:0] word);
        int unsigned w;
        int unsigned a;
        int unsigned v;
        w = word;
        a = addr % 4;
        v = 0;
        if (ld == LB || ld == LBU) begin
            v = (w >> (8 * a)) % 256;
            if (ld == LB && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (ld == LH || ld == LHU) begin
            v = (w >> (16 * (a / 2))) % 65536;
            if (ld == LH && v >= 32768) v = v + 32'hFFFF_0000;
        end else if (ld == LW) begin
            v = w;
        end
        return v;
    endfunction

    task automatic checkEq(input string tag, input logic [69:0] observed, input logic [69:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic resetModel();
        mPc = '0; mRfWe = 1'b0; mWaddr = '0; mResult = '0; mSel = 1'b0;
        mLoad = '0; mHiLo = '0; mIsLoad = 1'b0; mHave = 1'b0; mData = '0;
    endtask

    task automatic checkOutput();
        logic        expStall;
        logic [31:0] expWdata;
        logic        known;
        expStall = mIsLoad && !mHave && !rvalid;
        known    = 1'b1;
        expWdata = mResult;
        if (mSel) begin
            if (mHave) expWdata = extendLoad(mLoad, mResult, mData);
            else if (rvalid || !mIsLoad) expWdata = extendLoad(mLoad, mResult, rdata);
            else begin
                known    = 1'b0;
                expWdata = '0;
            end
        end
        checkEq("stallreq", 70'(stallReq), 70'(expStall));
        checkEq("hilo", 70'(hiLoOut), 70'(mHiLo));
        if (known) begin
            checkEq("wb_bus", wbBus, {mPc, mRfWe, mWaddr, expWdata});
            checkEq("rf_bus", 70'(rfBus), 70'({mRfWe, mWaddr, expWdata}));
        end else begin
            checkEq("wb_ctrl", 70'(wbBus[69:32]), 70'({mPc, mRfWe, mWaddr}));
            checkEq("rf_ctrl", 70'(rfBus[37:32]), 70'({mRfWe, mWaddr}));
        end
    endtask

    task automatic driveInputs(input logic [5:0] st, input logic [75:0] ex, input logic [4:0] ld,
                               input logic [65:0] hl, input logic rv, input logic [31:0] rd);
        stall   = st;
        exBus   = ex;
        loadBus = ld;
        hiLoBus = hl;
        rvalid  = rv;
        rdata   = rd;
    endtask

    // Clock edge: the model moves the same way the stage should, from the current inputs
    task automatic advance();
        @(posedge clk);
        if (stall[3] && !stall[4]) begin
            resetModel();
        end else if (!stall[3]) begin
            {mPc, mRfWe, mWaddr, mResult} = {exBus[75:44], exBus[37], exBus[36:32], exBus[31:0]};
            mSel    = exBus[38];
            mLoad   = loadBus;
            mHiLo   = hiLoBus;
            mIsLoad = exBus[43] && (exBus[42:39] == 4'h0) && (loadBus != 5'b0);
            mHave   = 1'b0;
        end else if (mIsLoad && !mHave && rvalid) begin
            mHave = 1'b1;
            mData = rdata;
        end
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] st, input logic [75:0] ex, input logic [4:0] ld,
                                 input logic [65:0] hl, input logic rv, input logic [31:0] rd);
        driveInputs(st, ex, ld, hl, rv, rd);
        #3;
        checkOutput();
        advance();
    endtask

    logic [75:0] nop;
    logic [75:0] ex;
    logic [4:0]  ld;
    logic [65:0] hl;
    logic [5:0]  st;
    logic        rv;
    logic        pending;
    int          kind;
    int          mode;

    initial begin
        checkCount = 0;
        passCount  = 0;
        nop        = mkEx(32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        resetModel();
        rst = 1'b1;
        driveInputs(RUN, nop, 5'b0, 66'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        checkEq("reset_wb", wbBus, 70'b0);
        rst = 1'b0;

        $display("[TB] lb/lbu with zero-wait response");
        applyStimulus(RUN, mkEx(32'hBFC0_0000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5, 32'h0000_1003), LB, 66'b0, 1'b0, 32'h0);
        driveInputs(RUN, mkEx(32'hBFC0_0004, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h0000_2003), LBU, 66'b0, 1'b1, 32'h8011_2233);
        #3;
        checkOutput();
        checkEq("t1_lb_stall", 70'(stallReq), 70'd0);
        checkEq("t1_lb_wdata", 70'(wbBus[31:0]), 70'h0_FFFF_FF80);
        advance();
        driveInputs(RUN, nop, 5'b0, 66'b0, 1'b1, 32'h8011_2233);
        #3;
        checkOutput();
        checkEq("t1_lbu_wdata", 70'(wbBus[31:0]), 70'h0_0000_0080);
        advance();

        $display("[TB] lh with 3-cycle response latency");
        applyStimulus(RUN, mkEx(32'hBFC0_0010, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h0000_3002), LH, 66'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            driveInputs(HOLD, nop, 5'b0, 66'b0, 1'b0, $urandom);
            #3;
            checkOutput();
            checkEq("t2_stall_high", 70'(stallReq), 70'd1);
            advance();
        end
        driveInputs(RUN, nop, 5'b0, 66'b0, 1'b1, 32'h8001_7FFF);
        #3;
        checkOutput();
        checkEq("t2_stall_low", 70'(stallReq), 70'd0);
        checkEq("t2_lh_wdata", 70'(wbBus[31:0]), 70'h0_FFFF_8001);
        advance();

        $display("[TB] lw response parked while MEM is held");
        applyStimulus(RUN, mkEx(32'hBFC0_0020, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h0000_4001), LW, 66'b0, 1'b0, 32'h0);
        applyStimulus(HOLD, nop, 5'b0, 66'b0, 1'b1, 32'hCAFE_F00D);
        for (int i = 0; i < 2; i++) begin
            driveInputs(HOLD, nop, 5'b0, 66'b0, i[0], 32'hDEAD_BEEF);
            #3;
            checkOutput();
            checkEq("t3_hold_wdata", 70'(wbBus[31:0]), 70'h0_CAFE_F00D);
            advance();
        end
        driveInputs(RUN, nop, 5'b0, 66'b0, 1'b0, 32'h1234_5678);
        #3;
        checkOutput();
        checkEq("t3_wb_word", 70'(wbBus[31:0]), 70'h0_CAFE_F00D);
        advance();

        $display("[TB] store completes without waiting");
        applyStimulus(RUN, mkEx(32'hBFC0_0030, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_5000), 5'b0, 66'b0, 1'b0, 32'h0);
        driveInputs(RUN, nop, 5'b0, 66'b0, 1'b0, 32'h0);
        #3;
        checkOutput();
        checkEq("t4_stall", 70'(stallReq), 70'd0);
        checkEq("t4_rf_we", 70'(wbBus[37]), 70'd0);
        advance();

        $display("[TB] asynchronous reset during a pending load");
        applyStimulus(RUN, mkEx(32'hBFC0_0040, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h0000_6000), LW, 66'h3_0000_0001_0000_0002, 1'b0, 32'h0);
        driveInputs(HOLD, nop, 5'b0, 66'b0, 1'b0, 32'h0);
        #3;
        checkOutput();
        rst = 1'b1;
        #1;
        resetModel();
        checkOutput();
        checkEq("t5_async_wb", wbBus, 70'b0);
        checkEq("t5_async_stall", 70'(stallReq), 70'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        driveInputs(HOLD, nop, 5'b0, 66'b0, 1'b1, 32'hFFFF_FFFF);
        #3;
        checkOutput();
        checkEq("t5_late_rvalid_stall", 70'(stallReq), 70'd0);
        advance();
        applyStimulus(RUN, nop, 5'b0, 66'b0, 1'b0, 32'h0);

        $display("[TB] bubble after an addu");
        applyStimulus(RUN, mkEx(32'hBFC0_0050, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10, 32'h0000_00AB), 5'b0, 66'h2_1111_1111_2222_2222, 1'b0, 32'h0);
        applyStimulus(BUBBLE, nop, 5'b0, 66'b0, 1'b0, 32'h0);
        driveInputs(RUN, nop, 5'b0, 66'b0, 1'b0, 32'h0);
        #3;
        checkOutput();
        checkEq("t6_bubble_wb", wbBus, 70'b0);
        checkEq("t6_bubble_hilo", 70'(hiLoOut), 70'b0);
        advance();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 3);
            hl   = {2'($urandom), 32'($urandom), 32'($urandom)};
            ld   = 5'b0;
            if (kind == 0 || kind == 3) begin
                ld = 5'b00001 << $urandom_range(0, 4);
                ex = mkEx($urandom, 1'b1, 4'h0, 1'b1, 1'b1, 5'($urandom), $urandom);
            end else if (kind == 1) begin
                ex = mkEx($urandom, 1'b1, 4'($urandom_range(1, 15)), 1'b0, 1'b0, 5'($urandom), $urandom);
            end else begin
                ex = mkEx($urandom, 1'b0, 4'h0, 1'b0, 1'($urandom), 5'($urandom), $urandom);
            end
            pending = mIsLoad && !mHave;
            rv      = pending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mode    = $urandom_range(0, 9);
            if (pending && !rv) st = HOLD;
            else if (mode < 6) st = RUN;
            else if (mode < 9) st = HOLD;
            else st = BUBBLE;
            applyStimulus(st, ex, ld, hl, rv, $urandom);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
